// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the decode stage: opcodes, ALU op codes, control-bit
// positions and the NOP encoding.
package riscv_pkg;

    localparam int          RV_XLEN = 32;
    localparam logic [31:0] RV_NOP  = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // id_ctrl = {alu_src,mem_read,mem_write,reg_write,mem_to_reg,branch,jump}
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_JUMP       = 0;

    // Only R, S and B formats carry a real rs2 field.
    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX register bundle handed from the decode stage to execute.
interface id_stage_if;
    import riscv_pkg::*;

    logic               id_valid;
    logic [RV_XLEN-1:0] id_pc;
    logic [RV_XLEN-1:0] id_rs1_data;
    logic [RV_XLEN-1:0] id_rs2_data;
    logic [RV_XLEN-1:0] id_imm;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic [4:0]         id_rd;
    logic [3:0]         id_alu_op;
    logic [6:0]         id_ctrl;
    logic               id_illegal;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_ctrl, id_illegal
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_ctrl, id_illegal
    );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file, 2 async reads / 1 sync write, x0 hardwired to zero.
// Define ID_RF_BYPASS_EN to make a same-cycle write visible on the read ports.
module id_stage_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [1:31];
    logic            wr_en;

    assign wr_en = we && (wr_addr != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`ifdef ID_RF_BYPASS_EN
        // wr_en already excludes x0, so x0 stays zero under write-through.
        if (wr_en && (wr_addr == rs1_addr)) rs1_data = wr_data;
        if (wr_en && (wr_addr == rs2_addr)) rs2_data = wr_data;
`else
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, regfile, decoder/immgen, load-use stall, ID/EX register.
// Optional ID_RF_BYPASS_EN selects write-through regfile reads (see id_stage_regfile).
module id_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN      = RV_XLEN,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            pc_write,
    id_stage_if.master      idex
);

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
        return {{(XLEN-12){i[31]}}, i[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] i);
        return {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
        return {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
        return {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
        return {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // sub/sra selection: bit 30 picks SUB only for register-register ops.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic b30,
                                            input logic is_op);
        case (f3)
            3'b000:  return (is_op && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return b30 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0]     instr_p0;
    logic [XLEN-1:0] pc_p0;
    logic            vld_p0;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
    logic [4:0]      rs1_p1, rs2_p1, rd_p1;
    logic [3:0]      alu_op_p1;
    logic [6:0]      ctrl_p1;
    logic            illegal_p1;

    logic [6:0]      opc;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic            stall;
    logic            kill_p1;

    logic [XLEN-1:0] dec_imm;
    alu_op_e         dec_alu;
    logic [6:0]      dec_ctrl;
    logic            dec_ill;
    logic            dec_rw;

    // IF/ID stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_p0 <= NOP_INSTR;
            pc_p0    <= '0;
            vld_p0   <= 1'b0;
        end else if (flush) begin
            instr_p0 <= NOP_INSTR;
            pc_p0    <= '0;
            vld_p0   <= 1'b0;
        end else if (!stall) begin
            instr_p0 <= instr;
            pc_p0    <= pc_in;
            vld_p0   <= 1'b1;
        end
    end

    assign opc   = instr_p0[6:0];
    assign rs1_f = instr_p0[19:15];
    assign rs2_f = instr_p0[24:20];
    assign rd_f  = instr_p0[11:7];

    assign stall = ex_mem_read && (ex_rd != 5'd0) &&
                   ((ex_rd == rs1_f) || (reads_rs2(opc) && (ex_rd == rs2_f)));

    assign pc_write = !reset || flush || !stall;
    assign kill_p1  = flush || stall || !vld_p0;

    id_stage_regfile #(.XLEN(XLEN)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_f),
        .rs2_addr (rs2_f),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .we       (wb_we),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    always_comb begin
        dec_imm  = '0;
        dec_alu  = ALU_ADD;
        dec_ctrl = '0;
        dec_ill  = 1'b0;
        dec_rw   = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_imm = imm_u(instr_p0); dec_alu = ALU_PASSB;
                dec_ctrl[CTRL_ALU_SRC] = 1'b1; dec_rw = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm = imm_u(instr_p0);
                dec_ctrl[CTRL_ALU_SRC] = 1'b1; dec_rw = 1'b1;
            end
            OPC_JAL: begin
                dec_imm = imm_j(instr_p0);
                dec_ctrl[CTRL_JUMP] = 1'b1; dec_rw = 1'b1;
            end
            OPC_JALR: begin
                dec_imm = imm_i(instr_p0);
                dec_ctrl[CTRL_ALU_SRC] = 1'b1; dec_ctrl[CTRL_JUMP] = 1'b1; dec_rw = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm = imm_b(instr_p0); dec_alu = ALU_SUB;
                dec_ctrl[CTRL_BRANCH] = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm = imm_i(instr_p0);
                dec_ctrl[CTRL_ALU_SRC]    = 1'b1;
                dec_ctrl[CTRL_MEM_READ]   = 1'b1;
                dec_ctrl[CTRL_MEM_TO_REG] = 1'b1;
                dec_rw = 1'b1;
            end
            OPC_STORE: begin
                dec_imm = imm_s(instr_p0);
                dec_ctrl[CTRL_ALU_SRC] = 1'b1; dec_ctrl[CTRL_MEM_WRITE] = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm = imm_i(instr_p0);
                dec_alu = alu_from_f3(instr_p0[14:12], instr_p0[30], 1'b0);
                dec_ctrl[CTRL_ALU_SRC] = 1'b1; dec_rw = 1'b1;
            end
            OPC_OP: begin
                dec_alu = alu_from_f3(instr_p0[14:12], instr_p0[30], 1'b1);
                dec_rw  = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        // Writes to x0 never reach WB, which also makes NOP side-effect free.
        dec_ctrl[CTRL_REG_WRITE] = dec_rw && (rd_f != 5'd0);
    end

    // ID/EX stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || kill_p1) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            alu_op_p1   <= '0;
            ctrl_p1     <= '0;
            illegal_p1  <= 1'b0;
        end else begin
            vld_p1      <= 1'b1;
            pc_p1       <= pc_p0;
            rs1_data_p1 <= rf_rs1_data;
            rs2_data_p1 <= rf_rs2_data;
            imm_p1      <= dec_imm;
            rs1_p1      <= rs1_f;
            rs2_p1      <= rs2_f;
            rd_p1       <= rd_f;
            alu_op_p1   <= dec_alu;
            ctrl_p1     <= dec_ctrl;
            illegal_p1  <= dec_ill;
        end
    end

    assign idex.id_valid    = vld_p1;
    assign idex.id_pc       = pc_p1;
    assign idex.id_rs1_data = rs1_data_p1;
    assign idex.id_rs2_data = rs2_data_p1;
    assign idex.id_imm      = imm_p1;
    assign idex.id_rs1      = rs1_p1;
    assign idex.id_rs2      = rs2_p1;
    assign idex.id_rd       = rd_p1;
    assign idex.id_alu_op   = alu_op_p1;
    assign idex.id_ctrl     = ctrl_p1;
    assign idex.id_illegal  = illegal_p1;

endmodule
